// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: FSM states,
// cfg_bits / cfg_parity codes and frame helper functions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] BITS_5 = 2'b00;
    localparam logic [1:0] BITS_6 = 2'b01;
    localparam logic [1:0] BITS_7 = 2'b10;
    localparam logic [1:0] BITS_8 = 2'b11;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    // Index of the last data bit sent for a given data length code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
        logic [2:0] r;
        r = 3'd7;
        case (bits)
            BITS_5: r = 3'd4;
            BITS_6: r = 3'd5;
            BITS_7: r = 3'd6;
            BITS_8: r = 3'd7;
        endcase
        return r;
    endfunction

    function automatic logic parity_en(input logic [1:0] parity);
        logic r;
        r = 1'b0;
        case (parity)
            PAR_EVEN, PAR_ODD:      r = 1'b1;
            PAR_NONE, PAR_NONE_ALT: r = 1'b0;
        endcase
        return r;
    endfunction

    // Parity covers only the bits actually sent; upper bits are masked off.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] bits,
                                        input logic [1:0] parity);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - bits);
        return (^(data & mask)) ^ (parity == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte write handshake into the transmitter FIFO.
interface uart_tx_cfg_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter; pushes while full and pops while empty
// are ignored, so callers may present requests unconditionally.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time frame format (5-8 data bits, parity, 1-2 stops)
// latched per byte at pop time, fed from a small FIFO.
//   state  | meaning
//   IDLE   | line high, waiting for a FIFO entry
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | optional parity bit
//   STOP   | one or two stop bits (high)
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_cfg_if.slave                  wr,
    input  logic [1:0]                    cfg_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int BAUD_TICK = CLOCK_FREQ / BAUD_RATE;
    localparam int CW        = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(BAUD_TICK - 1);

    tx_state_e     state;
    tx_state_e     state_next;
    logic [CW-1:0] baud_cnt;
    logic          tick;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    frame_data;
    logic [2:0]    frame_last;
    logic          frame_par_en;
    logic          frame_par_bit;
    logic          frame_stop2;
    logic          pop;
    logic          line;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr.wr_valid),
        .push_data (wr.wr_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr.wr_ready = !fifo_full;
    assign tick        = (baud_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        line       = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                line = 1'b0;
                if (tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                line = frame_data[bit_idx];
                if (tick && bit_idx == frame_last)
                    state_next = frame_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                line = frame_par_bit;
                if (tick) state_next = ST_STOP;
            end
            ST_STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (tick && stop_idx == frame_stop2) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Line and busy are registered from the current state, one clock behind it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx            <= 1'b1;
            tx_busy       <= 1'b0;
            overflow      <= 1'b0;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            frame_data    <= '0;
            frame_last    <= 3'd7;
            frame_par_en  <= 1'b0;
            frame_par_bit <= 1'b0;
            frame_stop2   <= 1'b0;
        end else begin
            tx       <= line;
            tx_busy  <= (state != ST_IDLE);
            overflow <= wr.wr_valid && fifo_full;

            if (state == ST_IDLE || tick) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + 1'b1;

            if (pop) begin
                frame_data    <= fifo_head;
                frame_last    <= last_bit_idx(cfg_bits);
                frame_par_en  <= parity_en(cfg_parity);
                frame_par_bit <= parity_bit(fifo_head, cfg_bits, cfg_parity);
                frame_stop2   <= cfg_stop2;
                bit_idx       <= '0;
                stop_idx      <= 1'b0;
            end else if (tick) begin
                if (state == ST_DATA && bit_idx != frame_last) bit_idx <= bit_idx + 1'b1;
                if (state == ST_STOP) stop_idx <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: accepted bytes are queued, a monitor
// rebuilds each frame from the format rules and compares the line cycle by cycle.
module tb_uart_tx_cfg;
    localparam int CLOCK_FREQ = 50_000_000;
    localparam int BAUD_RATE  = 1_000_000;
    localparam int FIFO_DEPTH = 4;
    localparam int BT         = CLOCK_FREQ / BAUD_RATE;

    typedef bit bitq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0] cfg_bits = 2'b11;
    logic [1:0] cfg_parity = 2'b00;
    logic cfg_stop2 = 1'b0;
    logic tx, tx_busy, overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_tx_cfg_if wr_if();

    uart_tx_cfg #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr_if),
        .cfg_bits   (cfg_bits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int frames_done = 0;
    int ovf_cycles = 0;
    int busy_run = 0;
    int last_busy_len = 0;
    int exp_start_cyc = 0;
    bit exp_start_valid = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] bdata[8];

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference frame: start, N data bits LSB first, optional parity, stop bits.
    function automatic bitq_t build_frame(logic [7:0] d, logic [1:0] b, logic [1:0] p, logic s2);
        bitq_t q;
        int n, ones;
        n = 5 + int'(b);
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(bit'(d[i]));
            ones += int'(d[i]);
        end
        if (p == 2'b01) q.push_back(bit'(ones % 2 == 1));
        else if (p == 2'b10) q.push_back(bit'(ones % 2 == 0));
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        return q;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (overflow === 1'b1) ovf_cycles++;
        if (tx_busy === 1'b1) busy_run++;
        else if (busy_run > 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
        end
    end

    // Monitor: pops an expected byte whenever a frame starts on the line.
    initial begin
        bitq_t bits;
        logic [7:0] d;
        logic got;
        bit chained, aborted;
        int nerr, busy_err, fidx;
        chained = 1'b0;
        fidx = 0;
        forever begin
            @(negedge clk);
            if (reset || exp_q.size() == 0) begin
                chained = 1'b0;
                continue;
            end
            if (!chained && tx !== 1'b0) continue;
            if (exp_start_valid) begin
                check("start latency", cyc, exp_start_cyc);
                exp_start_valid = 1'b0;
            end
            d = exp_q.pop_front();
            bits = build_frame(d, cfg_bits, cfg_parity, cfg_stop2);
            aborted = 1'b0;
            busy_err = 0;
            for (int b = 0; b < bits.size() && !aborted; b++) begin
                nerr = 0;
                got = tx;
                for (int k = 0; k < BT; k++) begin
                    if (!(b == 0 && k == 0)) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== logic'(bits[b])) begin
                        nerr++;
                        got = tx;
                    end
                    if (tx_busy !== 1'b1) busy_err++;
                end
                if (!aborted)
                    check($sformatf("frame%0d bit%0d", fidx, b),
                          (nerr == 0) ? int'(bits[b]) : int'(!bits[b]), int'(bits[b]));
            end
            if (aborted) begin
                exp_q.delete();
                chained = 1'b0;
                continue;
            end
            check($sformatf("frame%0d busy low cycles", fidx), busy_err, 0);
            fidx++;
            frames_done++;
            chained = (exp_q.size() > 0);
            if (!chained) begin
                @(negedge clk);
                if (!reset) begin
                    check("idle tx after frame", int'(tx), 1);
                    check("idle busy after frame", int'(tx_busy), 0);
                end
            end
        end
    end

    task automatic burst(input int n);
        int exp_cnt;
        @(negedge clk);
        exp_start_cyc = cyc + 3;
        exp_start_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data = bdata[i];
            if (i < FIFO_DEPTH + 1) exp_q.push_back(bdata[i]);
        end
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        @(negedge clk);
        exp_cnt = ((n < FIFO_DEPTH + 1) ? n : FIFO_DEPTH + 1) - 1;
        check("fifo_count after burst", int'(fifo_count), exp_cnt);
        check("wr_ready after burst", int'(wr_if.wr_ready), int'(exp_cnt < FIFO_DEPTH));
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames_done < target; i++) @(negedge clk);
        check("frames sent", frames_done, target);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_one(input logic [1:0] b, input logic [1:0] p, input logic s2,
                           input logic [7:0] d, input int exp_len);
        int base;
        cfg_bits = b;
        cfg_parity = p;
        cfg_stop2 = s2;
        bdata[0] = d;
        base = frames_done;
        last_busy_len = 0;
        burst(1);
        wait_frames(base + 1, 800);
        check($sformatf("frame length %0d-bit code", int'(b)), last_busy_len, exp_len);
    endtask

    initial begin
        int base, n, nfr, low_cycles;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data = 8'h00;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx", int'(tx), 1);
        check("reset busy", int'(tx_busy), 0);
        check("reset overflow", int'(overflow), 0);
        check("reset fifo_count", int'(fifo_count), 0);
        check("reset wr_ready", int'(wr_if.wr_ready), 1);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("no frame without write", int'(tx_busy), 0);

        run_one(2'b11, 2'b00, 1'b0, 8'hA5, 500);
        run_one(2'b10, 2'b01, 1'b1, 8'h53, 550);
        run_one(2'b00, 2'b10, 1'b0, 8'hFF, 400);

        // Six back-to-back writes: one popped, four queued, last dropped.
        cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        for (int i = 0; i < 6; i++) bdata[i] = 8'($urandom);
        base = frames_done;
        ovf_cycles = 0;
        last_busy_len = 0;
        burst(6);
        wait_frames(base + 5, 5 * 600);
        check("overflow pulses", ovf_cycles, 1);
        check("back-to-back busy length", last_busy_len, 5 * 500);

        // Parity change mid-frame applies to the next frame only.
        cfg_bits = 2'b11; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
        bdata[0] = 8'h01; bdata[1] = 8'h01;
        base = frames_done;
        burst(2);
        repeat (5 * BT) @(negedge clk);
        cfg_parity = 2'b10;
        wait_frames(base + 2, 1500);

        for (int it = 0; it < 6; it++) begin
            cfg_bits = 2'($urandom_range(0, 3));
            cfg_parity = 2'($urandom_range(0, 3));
            cfg_stop2 = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) bdata[i] = 8'($urandom);
            nfr = (n < FIFO_DEPTH + 1) ? n : FIFO_DEPTH + 1;
            base = frames_done;
            ovf_cycles = 0;
            burst(n);
            wait_frames(base + nfr, nfr * 12 * BT + 100);
            check("random overflow pulses", ovf_cycles, n - nfr);
        end

        // Reset while in DATA aborts the frame and empties the FIFO.
        cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        bdata[0] = 8'h3C; bdata[1] = 8'hC3;
        base = frames_done;
        burst(2);
        repeat (3 * BT) @(negedge clk);
        check("busy before reset", int'(tx_busy), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset mid-frame tx", int'(tx), 1);
        check("reset mid-frame fifo_count", int'(fifo_count), 0);
        check("reset mid-frame busy", int'(tx_busy), 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
        low_cycles = 0;
        repeat (1500) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) low_cycles++;
        end
        check("line activity after reset", low_cycles, 0);
        check("frames after reset", frames_done, base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 1_000_000, line rate; BAUD_TICK = CLOCK_FREQ/BAUD_RATE clocks per bit (default 50).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO depth; a power of 2, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port wr_valid, input, 1 bit, write request for one byte.
REQ-007 SHALL have port wr_data, input, 8 bits, byte to transmit, LSB first.
REQ-008 SHALL have port wr_ready, output, 1 bit, FIFO not full.
REQ-009 SHALL have port cfg_bits, input, 2 bits, data length: 00=5, 01=6, 10=7, 11=8.
REQ-010 SHALL have port cfg_parity, input, 2 bits, parity: 00=none, 01=even, 10=odd, 11=none.
REQ-011 SHALL have port cfg_stop2, input, 1 bit, 0=one stop bit, 1=two stop bits.
REQ-012 SHALL have port tx, output, 1 bit, registered serial line, idle high.
REQ-013 SHALL have port tx_busy, output, 1 bit, high while a frame is on the line.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, number of FIFO entries.
REQ-015 SHALL have port overflow, output, 1 bit, one-cycle pulse when a write is dropped.

Function
REQ-016 SHALL accept a byte on each edge where wr_valid && wr_ready.
REQ-017 SHALL assert wr_ready = (fifo_count < FIFO_DEPTH).
REQ-018 SHALL, on wr_valid with FIFO full, drop the byte and pulse overflow for one cycle.
REQ-019 SHALL, with the FIFO not full, perform a push and a pop in the same cycle; fifo_count is then unchanged.
REQ-020 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP.
REQ-021 SHALL, in IDLE with the FIFO non-empty, pop the head byte and latch cfg_bits/cfg_parity/cfg_stop2 into frame registers.
REQ-022 SHALL ignore config input changes mid-frame; they apply from the next pop.
REQ-023 SHALL drive tx low exactly 2 clocks after the accepting edge when a byte is written into an empty FIFO while IDLE.
REQ-024 SHALL hold each bit (start, every data bit, parity, every stop bit) for exactly BAUD_TICK clocks.
REQ-025 SHALL send data bits LSB first, sending bits [N-1:0] only, where N is set by cfg_bits; upper bits are ignored.
REQ-026 SHALL send parity only when enabled: even = XOR of the N data bits; odd = its inverse.
REQ-027 SHALL transition START->DATA, then DATA->PARITY or DATA->STOP (parity none), then PARITY->STOP.
REQ-028 SHALL send 1 or 2 stop bits; STOP lasts 1 or 2 bit periods.
REQ-029 SHALL, at the end of the final stop bit, go STOP->START with an immediate pop if the FIFO is non-empty (no idle gap); otherwise STOP->IDLE.
REQ-030 SHALL assert tx_busy from the cycle tx first goes low until the last stop-bit cycle, and deassert it in IDLE.
REQ-031 SHALL use a baud counter of width $clog2(BAUD_TICK) that wraps to 0 at BAUD_TICK-1.

Reset
REQ-032 SHALL, on reset, asynchronously force tx=1, tx_busy=0, overflow=0, fifo_count=0, wr_ready=1 and state=IDLE.
REQ-033 SHALL, on reset mid-frame, abort the frame, discard FIFO contents and hold the line high.
REQ-034 SHALL start the first frame after reset release only after a new write.

Structure
REQ-035 SHALL place state encodings, cfg_parity codes and cfg_bits codes in shared package uart_pkg.
REQ-036 SHALL implement the FIFO as sub-module uart_tx_fifo (parameter DEPTH, width 8, count/full/empty outputs).
REQ-037 SHALL keep the FSM and baud counter in uart_tx_cfg.

Verification
REQ-038 Bench SHALL cover: 8N1, write 0xA5 -> tx low at +2 clk, bits 1,0,1,0,0,1,0,1, one stop; frame = 500 clk.
REQ-039 Bench SHALL cover: 7E2, write 0x53 -> 7 data bits 1,1,0,0,1,0,1, parity 0, two stop bits; frame = 550 clk.
REQ-040 Bench SHALL cover: 5O1, write 0xFF -> data 1,1,1,1,1, parity 0; bits [7:5] ignored; frame = 400 clk.
REQ-041 Bench SHALL cover: 6 back-to-back writes at depth 4 while IDLE -> 1 popped plus 4 queued, last write gives overflow pulse and is dropped, 5 frames sent with no idle gap.
REQ-042 Bench SHALL cover: cfg_parity changed mid-frame -> current frame unchanged, next frame uses the new parity.
REQ-043 Bench SHALL cover: reset asserted in DATA -> tx=1 and fifo_count=0 in the same cycle, with no further frames after release.
